// File: rtl/niosii_system_nios2_qsys_0_div_cell_pkg.sv
// Shared constants and state encoding for the Nios II iterative divider cell.
package niosII_system_nios2_qsys_0_div_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_ITER_W = $clog2(DIV_DATA_W);
  localparam logic [DIV_DATA_W-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/niosii_system_nios2_qsys_0_div_cell_if.sv
// A-stage divide request/response bundle between the pipeline and the divider cell.
interface niosii_system_nios2_qsys_0_div_cell_if #(
  parameter int unsigned DATA_W = 32
);

  logic [DATA_W-1:0] A_div_src1;
  logic [DATA_W-1:0] A_div_src2;
  logic              A_div_signed;
  logic              A_div_start;
  logic              A_div_busy;
  logic              A_div_done;
  logic [DATA_W-1:0] A_div_quotient;
  logic [DATA_W-1:0] A_div_remainder;

  modport master (
    output A_div_src1, A_div_src2, A_div_signed, A_div_start,
    input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );

  modport slave (
    input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
    output A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );

endinterface

// File: rtl/niosii_system_nios2_qsys_0_div_cell_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract if it fits.
module niosII_system_nios2_qsys_0_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem_i < divisor_i always holds, so DATA_W+1 bits suffice for the sign of the trial.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_bit_o = ~trial[DATA_W];
    rem_o   = q_bit_o ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/niosii_system_nios2_qsys_0_div_cell.sv
// Iterative 32-bit signed/unsigned divider: one quotient bit per clock, fixed latency.
module niosii_system_nios2_qsys_0_div_cell
  import niosII_system_nios2_qsys_0_div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input logic clk,
  input logic reset_n,
  niosii_system_nios2_qsys_0_div_cell_if.slave div
);

  localparam logic [DIV_ITER_W-1:0] CNT_INIT = DIV_ITER_W'(DATA_W - 1);

  div_state_e              state_q, state_d;
  logic [DIV_ITER_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]       rem_q, rem_d;
  logic [DATA_W-1:0]       dvd_q, dvd_d;
  logic [DATA_W-1:0]       divisor_q, divisor_d;
  logic [DATA_W-1:0]       src1_q, src1_d;
  logic                    neg_q_q, neg_q_d;
  logic                    neg_r_q, neg_r_d;
  logic                    dz_q, dz_d;
  logic [DATA_W-1:0]       quot_q, quot_d;
  logic [DATA_W-1:0]       remo_q, remo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_W-1:0]       step_rem;
  logic                    step_qbit;
  logic                    sign1, sign2;

  niosII_system_nios2_qsys_0_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DATA_W-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    src1_d    = src1_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dz_d      = dz_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    sign1     = div.A_div_signed & div.A_div_src1[DATA_W-1];
    sign2     = div.A_div_signed & div.A_div_src2[DATA_W-1];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (div.A_div_start) begin
          src1_d    = div.A_div_src1;
          dvd_d     = sign1 ? -div.A_div_src1 : div.A_div_src1;
          divisor_d = sign2 ? -div.A_div_src2 : div.A_div_src2;
          neg_q_d   = sign1 ^ sign2;
          neg_r_d   = sign1;
          dz_d      = (div.A_div_src2 == '0);
          rem_d     = '0;
          count_d   = CNT_INIT;
          state_d   = ST_ITER;
        end
      end
      ST_ITER: begin
        // Quotient bits are shifted into the low end of the dividend register.
        rem_d = step_rem;
        dvd_d = {dvd_q[DATA_W-2:0], step_qbit};
        if (count_q == '0) begin
          state_d = ST_FIX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      ST_FIX: begin
        if (dz_q) begin
          quot_d = DIV_BY_ZERO_Q;
          remo_d = src1_q;
        end else begin
          quot_d = neg_q_q ? -dvd_q : dvd_q;
          remo_d = neg_r_q ? -rem_q : rem_q;
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ITER) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      src1_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      src1_q    <= src1_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dz_q      <= dz_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign div.A_div_busy      = busy_q;
  assign div.A_div_done      = done_q;
  assign div.A_div_quotient  = quot_q;
  assign div.A_div_remainder = remo_q;

endmodule
